// File: rtl/i2s_tx.sv
// I2S transmitter for the CS4344 DAC: one 24-bit sample per 256-clk frame, SCLK = clk/4, LRCK = clk/256.
// Build option I2S_TX_MONO_DUP_EN: when defined, the right channel carries the same sample as the left.
module i2s_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] din,
  input  logic        din_valid,
  output logic        tx_lrck,
  output logic        tx_sclk,
  output logic        tx_sdout,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned FRAME_LEN = 256;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam int unsigned DW        = 24;
  localparam int unsigned SLOT_W    = 5;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic [DW-1:0]     left_q, left_d;
  logic [DW-1:0]     right_q, right_d;
  logic              fresh_q, fresh_d;
  logic              load_q, load_d;
  logic              ur_pend_q, ur_pend_d;
  logic              lrck_q, lrck_d;
  logic              sclk_q, sclk_d;
  logic              sdout_q, sdout_d;
  logic              fs_q, fs_d;
  logic              ur_q, ur_d;

  logic              wrap_c;
  logic [DW-1:0]     next_word_c;
  logic [DW-1:0]     cur_word_c;
  logic [SLOT_W-1:0] slot_c;
  logic [SLOT_W-1:0] bit_idx_c;

  // Next-state: sample buffering, frame load and slot serialization
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    fresh_d   = fresh_q;
    ur_pend_d = ur_pend_q;
    sdout_d   = 1'b0;

    wrap_c      = (cnt_q == CNT_W'(FRAME_LEN - 1));
    next_word_c = din_valid ? din : hold_q;
    load_d      = wrap_c;

    if (din_valid) begin
      hold_d  = din;
      fresh_d = 1'b1;
    end

    // A strobe coinciding with the load bypasses straight into the frame
    if (wrap_c) begin
      left_d    = next_word_c;
`ifdef I2S_TX_MONO_DUP_EN
      right_d   = next_word_c;
`else
      right_d   = '0;
`endif
      fresh_d   = 1'b0;
      ur_pend_d = !fresh_q && !din_valid;
    end

    // Pulses land one clk after the load edge, together with LRCK falling
    fs_d = load_q;
    ur_d = load_q && ur_pend_q;

    lrck_d     = cnt_q[CNT_W-1];
    sclk_d     = cnt_q[1];
    slot_c     = cnt_q[CNT_W-2:2];
    cur_word_c = cnt_q[CNT_W-1] ? right_q : left_q;
    bit_idx_c  = SLOT_W'(DW) - slot_c;
    if ((slot_c >= SLOT_W'(1)) && (slot_c <= SLOT_W'(DW))) begin
      sdout_d = cur_word_c[bit_idx_c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      fresh_q   <= 1'b0;
      load_q    <= 1'b0;
      ur_pend_q <= 1'b0;
      lrck_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdout_q   <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      fresh_q   <= fresh_d;
      load_q    <= load_d;
      ur_pend_q <= ur_pend_d;
      lrck_q    <= lrck_d;
      sclk_q    <= sclk_d;
      sdout_q   <= sdout_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
    end
  end

  assign tx_lrck     = lrck_q;
  assign tx_sclk     = sclk_q;
  assign tx_sdout    = sdout_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: driver queues expected frames, a monitor deserializes each frame and compares.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic        din_valid = 1'b0;
  logic        tx_lrck, tx_sclk, tx_sdout, frame_start, underrun;

  i2s_tx dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .tx_lrck    (tx_lrck),
    .tx_sclk    (tx_sclk),
    .tx_sdout   (tx_sdout),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        ur;
  } exp_t;

  exp_t q_exp[$];
  int   total = 0;
  int   bad   = 0;

  // Reference phase counter: tcnt mirrors the master-clock frame position
  int unsigned tcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= 0;
    else     tcnt <= (tcnt + 1) % 256;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [23:0] l, input logic ur);
    exp_t e;
    e.l = l;
`ifdef I2S_TX_MONO_DUP_EN
    e.r = l;
`else
    e.r = '0;
`endif
    e.ur = ur;
    q_exp.push_back(e);
  endtask

  task automatic wait_cnt(input int unsigned c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tcnt != c && n < 300);
    if (tcnt != c) chk("wait_cnt_timeout", 32'(tcnt), 32'(c));
  endtask

  task automatic drive_at(input int unsigned c, input logic [23:0] d);
    wait_cnt(c);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_lrck"},  32'(tx_lrck),     32'd0);
    chk({tag, "_sclk"},  32'(tx_sclk),     32'd0);
    chk({tag, "_sdout"}, 32'(tx_sdout),    32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_ur"},    32'(underrun),    32'd0);
  endtask

  // Monitor: deserialize one 64-slot frame per frame_start and compare against the queue head
  int          k = 0;
  bit          active = 0;
  logic [63:0] bits;
  bit          fmt_err;
  logic        ur_cap;

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      if (frame_start) begin
        active  = 1;
        k       = 0;
        bits    = '0;
        fmt_err = 0;
        ur_cap  = underrun;
      end else if (active) begin
        k++;
      end
      if (active) begin
        if (tx_lrck !== k[7] || tx_sclk !== k[1]) fmt_err = 1;
        if (k != 0 && (frame_start === 1'b1 || underrun === 1'b1)) fmt_err = 1;
        if (k % 4 == 2) bits[k/4] = tx_sdout;
        if (k == 255) begin
          logic [23:0] gl, gr;
          bit          zero_ok;
          exp_t        e;
          for (int i = 0; i < 24; i++) begin
            gl[23-i] = bits[1+i];
            gr[23-i] = bits[33+i];
          end
          zero_ok = 1;
          for (int j = 0; j < 64; j++)
            if (((j % 32) == 0 || (j % 32) > 24) && bits[j] !== 1'b0) zero_ok = 0;
          if (q_exp.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = q_exp.pop_front();
            chk("left_word",  32'(gl),      32'(e.l));
            chk("right_word", 32'(gr),      32'(e.r));
            chk("pad_slots",  32'(zero_ok), 32'd1);
            chk("underrun",   32'(ur_cap),  32'(e.ur));
            chk("framing",    32'(fmt_err), 32'd0);
          end
          active = 0;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Sample mid-frame, then a sample followed by two starved frames
    push_exp(24'h800001, 1'b0);
    drive_at(100, 24'h800001);
    push_exp(24'h123456, 1'b0);
    drive_at(100, 24'h123456);
    push_exp(24'h123456, 1'b1);
    push_exp(24'h123456, 1'b1);
    wait_cnt(100);
    wait_cnt(100);
    wait_cnt(100);

    // Strobe exactly on the load edge, then starved frame replays it
    push_exp(24'h7FFFFF, 1'b0);
    drive_at(255, 24'h7FFFFF);
    push_exp(24'h7FFFFF, 1'b1);
    wait_cnt(100);

    // Two strobes in one frame: last one wins
    push_exp(24'h000BBB, 1'b0);
    drive_at(50, 24'h000AAA);
    drive_at(200, 24'h000BBB);

    push_exp(24'hC00000, 1'b0);
    drive_at(10, 24'hC00000);

    // Reset mid-word while the next frame is being shifted out
    wait_cnt(10);
    wait_cnt(10);
    wait_cnt(37);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_exp(24'h000000, 1'b1);

    n = 0;
    while (q_exp.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("frames_pending", 32'(q_exp.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
